// File: rtl/truth_table_sweep_ctrl_if.sv
// truth_table_sweep_ctrl_if: host/gate-side signal bundle for the truth-table sweep sequencer
interface truth_table_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] gate_in;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [7:0] table_q;
  logic       match;
  logic [3:0] mismatch_cnt;
  logic [2:0] fail_idx;
  modport master (
    output start, abort, expected, gate_out,
    input  gate_in, busy, done, table_q, match, mismatch_cnt, fail_idx
  );
  modport slave (
    input  start, abort, expected, gate_out,
    output gate_in, busy, done, table_q, match, mismatch_cnt, fail_idx
  );
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// truth_table_sweep_ctrl: sweeps a 3-input gate through all rows, majority-votes each, compares to expected
module truth_table_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input logic clk,
  input logic rst,
  truth_table_sweep_ctrl_if.slave bus
);
  localparam int CW = $clog2((SETTLE_CYCLES > SAMPLES ? SETTLE_CYCLES : SAMPLES) + 1);
  localparam int OW = $clog2(SAMPLES + 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d, ones_n;
  logic [7:0]    exp_q, exp_d, shadow_q, shadow_d, shadow_n, tbl_q, tbl_d, diff;
  logic          match_q, match_d, vote;
  logic [3:0]    mcnt_q, mcnt_d, pc;
  logic [2:0]    fidx_q, fidx_d, fi;
  // Result math always looks at the shadow with the current row's vote folded in
  always_comb begin
    ones_n = ones_q + OW'(bus.gate_out);
    vote = (2 * int'(ones_n)) > SAMPLES;
    shadow_n = shadow_q;
    shadow_n[row_q] = vote;
    diff = shadow_n ^ exp_q;
    pc = '0;
    fi = '0;
    for (int i = 7; i >= 0; i--) begin
      pc = pc + {3'b0, diff[i]};
      if (diff[i]) fi = 3'(i);
    end
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    ones_d = ones_q;
    exp_d = exp_q;
    shadow_d = shadow_q;
    tbl_d = tbl_q;
    match_d = match_q;
    mcnt_d = mcnt_q;
    fidx_d = fidx_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      row_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.abort) begin
          state_d = SETTLE;
          exp_d = bus.expected;
          row_d = '0;
          cnt_d = CW'(SETTLE_CYCLES);
          shadow_d = '0;
        end
        SETTLE: begin
          cnt_d = cnt_q == CW'(1) ? CW'(SAMPLES) : cnt_q - CW'(1);
          ones_d = '0;
          state_d = cnt_q == CW'(1) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          ones_d = ones_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            shadow_d = shadow_n;
            cnt_d = CW'(SETTLE_CYCLES);
            row_d = row_q == 3'd7 ? 3'd0 : row_q + 3'd1;
            state_d = row_q == 3'd7 ? DONE : SETTLE;
            if (row_q == 3'd7) begin
              tbl_d = shadow_n;
              match_d = diff == 8'd0;
              mcnt_d = pc;
              fidx_d = fi;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      cnt_q <= '0;
      ones_q <= '0;
      exp_q <= '0;
      shadow_q <= '0;
      tbl_q <= '0;
      match_q <= 1'b0;
      mcnt_q <= '0;
      fidx_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      exp_q <= exp_d;
      shadow_q <= shadow_d;
      tbl_q <= tbl_d;
      match_q <= match_d;
      mcnt_q <= mcnt_d;
      fidx_q <= fidx_d;
    end
  end
  assign bus.busy = state_q == SETTLE || state_q == SAMPLE;
  assign bus.done = state_q == DONE;
  assign bus.gate_in = bus.busy ? row_q : 3'd0;
  assign bus.table_q = tbl_q;
  assign bus.match = match_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.fail_idx = fidx_q;
endmodule
